apb_slave_regfile: RTL and testbench

APB completer that sits directly downstream of the team's APB requester (`pclk` domain) and terminates its transfers. It decodes a word-aligned address window at `BASE_ADDR` onto a small register file and inserts a programmable number of wait states before `pready`. It returns `prdata` and flags `pslverr` on bad or illegal accesses. The last register is a read-only count of completed transfers, used by the bench and by software as a liveness check.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_slave_regs.sv | 37 +++
 rtl/apb_slave_regfile.sv | 101 ++++++++++
 tb/tb_apb_slave_regfile.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} apb_slv_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int CNT_W      = 32;
  localparam int WAIT_W     = 4;

  localparam logic APB_ERR_NONE = 1'b0;
  localparam logic APB_ERR_SLV  = 1'b1;
endpackage

// File: rtl/apb_slave_regs.sv
// Register storage: NUM_REGS-1 RW words plus a read-only transfer counter
// in the last slot. Synchronous write port, combinational read port.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              inc,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] regs [NUM_REGS-1];
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS-1; i++) regs[i] <= '0;
      cnt <= '0;
    end else begin
      if (we && (int'(widx) < NUM_REGS-1)) regs[widx] <= wdata;
      if (inc) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(ridx) == NUM_REGS-1)     rdata = DATA_W'(cnt);
    else if (int'(ridx) < NUM_REGS-1) rdata = regs[ridx];
  end
endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: address decode, wait-state FSM and registered outputs
// in front of the apb_slave_regs storage.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = APB_ADDR_W,
  parameter int                DATA_W      = APB_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'hA000,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);
  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  apb_slv_state_t    state, nstate;
  logic [WAIT_W-1:0] wcnt;
  logic [IDX_W-1:0]  a_idx, dec_idx, ridx;
  logic              a_wr, a_err, dec_err, cur_err, cur_wr;
  logic [DATA_W-1:0] a_wdata, rdata;
  logic [ADDR_W-1:0] off, off_w;
  logic              setup, commit;

  assign setup   = psel && !penable;
  assign off     = paddr - BASE_ADDR;
  assign off_w   = off >> 2;
  assign dec_idx = off_w[IDX_W-1:0];
  assign dec_err = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
                   (off_w >= ADDR_W'(NUM_REGS)) ||
                   (pwrite && (off_w == ADDR_W'(NUM_REGS-1)));

  // With zero wait states READY is entered straight from the setup cycle,
  // so the read port and error flag must come from the live decode.
  assign ridx    = (state == ST_IDLE) ? dec_idx : a_idx;
  assign cur_err = (state == ST_IDLE) ? dec_err : a_err;
  assign cur_wr  = (state == ST_IDLE) ? pwrite  : a_wr;
  assign commit  = (state == ST_READY) && !a_err;

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (setup) nstate = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
      ST_WAIT:  if (!psel) nstate = ST_IDLE;
                else if (penable && wcnt == WAIT_W'(1)) nstate = ST_READY;
      ST_READY: nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      a_idx   <= '0;
      a_wr    <= 1'b0;
      a_err   <= APB_ERR_NONE;
      a_wdata <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= APB_ERR_NONE;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && setup) begin
        a_idx   <= dec_idx;
        a_wr    <= pwrite;
        a_err   <= dec_err;
        a_wdata <= pwdata;
        wcnt    <= WAIT_W'(WAIT_STATES);
      end else if (state == ST_WAIT && psel && penable && wcnt != WAIT_W'(1)) begin
        wcnt <= wcnt - WAIT_W'(1);
      end
      pready  <= (nstate == ST_READY);
      pslverr <= (nstate == ST_READY && cur_err) ? APB_ERR_SLV : APB_ERR_NONE;
      prdata  <= (nstate == ST_READY && !cur_err && !cur_wr) ? rdata : '0;
    end
  end

  apb_slave_regs #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regs (
    .clk   (pclk),
    .rst   (preset),
    .we    (commit && a_wr),
    .inc   (commit),
    .widx  (a_idx),
    .wdata (a_wdata),
    .ridx  (ridx),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers (WAIT_STATES 1, 0, 3) driven by a task that
// pushes model-derived expectations; a negedge monitor pops and compares.
module tb_apb_slave_regfile;
  localparam logic [31:0] BASE = 32'hA000;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic [2:0]       preset, psel, penable, pwrite, pready, pslverr;
  logic [2:0][31:0] paddr, pwdata, prdata;

  int          cyc = 0;
  int          tot = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] mreg [3][8];
  logic [31:0] mcnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_slave_regfile #(.WAIT_STATES(WS)) u_dut (
      .pclk(clk), .preset(preset[g]), .psel(psel[g]), .penable(penable[g]),
      .paddr(paddr[g]), .pwrite(pwrite[g]), .pwdata(pwdata[g]),
      .pready(pready[g]), .prdata(prdata[g]), .pslverr(pslverr[g])
    );
  end

  function automatic int ws_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  // Reference: window of 8 words at BASE, last word is the RO completion count.
  task automatic model(input int g, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, output exp_t e);
    longint off;
    int     idx;
    bit     err;
    off = longint'(addr) - longint'(BASE);
    idx = (off >= 0) ? int'(off / 4) : -1;
    err = (addr % 4 != 0) || (off < 0) || (idx >= 8) || (wr && idx == 7);
    e.inst = g;
    e.err  = err;
    e.data = 32'h0;
    if (!err) begin
      if (!wr) e.data = (idx == 7) ? mcnt[g] : mreg[g][idx];
      if (wr) mreg[g][idx] = data;
      mcnt[g] = mcnt[g] + 32'h1;
    end
  endtask

  task automatic setup(input int g, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data);
    psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = wr;
    paddr[g] = addr; pwdata[g] = data;
  endtask

  // Called and returns at #1 after a rising edge; leaves the bus idle
  // in the cycle after pready so a following call is back-to-back.
  task automatic xfer(input int g, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data);
    exp_t e;
    int   n;
    model(g, wr, addr, data, e);
    e.cyc = cyc + 1 + ws_of(g);
    sb.push_back(e);
    setup(g, wr, addr, data);
    @(posedge clk); #1;
    penable[g] = 1'b1;
    n = 0;
    while (!pready[g] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      tot++; bad++;
      $display("FAIL timeout inst=%0d addr=%h: no pready within 40 cycles", g, addr);
    end
    @(posedge clk); #1;
    psel[g] = 1'b0; penable[g] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      tot++;
      if (pready[g]) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pready inst=%0d cyc=%0d", g, cyc);
        end else begin
          e = sb.pop_front();
          if (e.inst != g || e.cyc != cyc || prdata[g] !== e.data || pslverr[g] !== e.err) begin
            bad++;
            $display("FAIL xfer inst=%0d: got cyc=%0d prdata=%h pslverr=%b, want inst=%0d cyc=%0d prdata=%h pslverr=%b",
                     g, cyc, prdata[g], pslverr[g], e.inst, e.cyc, e.data, e.err);
          end
        end
      end else if (prdata[g] !== 32'h0 || pslverr[g] !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs inst=%0d: prdata=%h pslverr=%b, want 0/0", g, prdata[g], pslverr[g]);
      end
    end
  end

  initial begin
    exp_t        e;
    int          g;
    logic [31:0] a;
    preset = 3'b111; psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 32'h0;
      for (int j = 0; j < 8; j++) mreg[i][j] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tot++;
      if (pready[i] !== 1'b0 || prdata[i] !== 32'h0 || pslverr[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d: pready=%b prdata=%h pslverr=%b, want 0", i, pready[i], prdata[i], pslverr[i]);
      end
    end
    preset = 3'b000;
    @(posedge clk); #1;

    // WS=1: write, read back, counter shows 2 completions
    xfer(0, 1'b1, 32'hA000, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'hA000, 32'h0);
    xfer(0, 1'b0, 32'hA01C, 32'h0);

    // WS=0: back-to-back reads, then error cases
    xfer(1, 1'b0, 32'hA004, 32'h0);
    xfer(1, 1'b0, 32'hA008, 32'h0);
    xfer(1, 1'b1, 32'hA01C, 32'h1111);
    xfer(1, 1'b0, 32'hA002, 32'h0);
    xfer(1, 1'b0, 32'h9FFC, 32'h0);
    xfer(1, 1'b0, 32'hA020, 32'h0);
    xfer(1, 1'b0, 32'hA01C, 32'h0);

    // WS=3: psel dropped in the second wait cycle of a write
    setup(2, 1'b1, 32'hA008, 32'h1234);
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    xfer(2, 1'b0, 32'hA008, 32'h0);
    xfer(2, 1'b0, 32'hA01C, 32'h0);

    // WS=1: reset lands in the READY cycle of a write; write must be dropped
    e.inst = 0; e.cyc = cyc + 2; e.data = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    setup(0, 1'b1, 32'hA004, 32'h55);
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    preset[0] = 1'b1;
    @(posedge clk); #1;
    tot++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid inst=0: pready=%b prdata=%h pslverr=%b, want 0", pready[0], prdata[0], pslverr[0]);
    end
    psel[0] = 1'b0; penable[0] = 1'b0; preset[0] = 1'b0;
    mcnt[0] = 32'h0;
    for (int j = 0; j < 8; j++) mreg[0][j] = 32'h0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'hA004, 32'h0);
    xfer(0, 1'b0, 32'hA01C, 32'h0);

    // Counter wrap
    force g_dut[0].u_dut.u_regs.cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release g_dut[0].u_dut.u_regs.cnt;
    mcnt[0] = 32'hFFFF_FFFF;
    xfer(0, 1'b0, 32'hA000, 32'h0);
    xfer(0, 1'b0, 32'hA01C, 32'h0);

    // Random traffic across all three instances
    for (int k = 0; k < 80; k++) begin
      g = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0:       a = BASE + 32'h1 + 32'($urandom_range(0, 30));
        1:       a = BASE - 32'h4 * 32'($urandom_range(1, 3));
        default: a = BASE + 32'h4 * 32'($urandom_range(0, 9));
      endcase
      xfer(g, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 3; i++) xfer(i, 1'b0, 32'hA01C, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    tot++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected responses never seen, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
